// File: rtl/toggle_event_decoder_pkg.sv
// Package for the toggle event decoder: FSM state encoding and counter helpers.
//   dec_state_t : IDLE (count==0), PEND (0<count<MAX), FULL (count==MAX)
//   cnt_max(w)  : saturation value of a w-bit pending-event counter (2**w-1)
package toggle_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        FULL = 2'd2
    } dec_state_t;

    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/toggle_event_decoder_if.sv
// Consumer-side handshake of the toggle event decoder.
//   evt_valid : high while the pending count is non-zero
//   evt_ready : consumer takes one event when evt_valid & evt_ready
//   evt_count : current pending-event count
// Modports: master = decoder (drives valid/count), slave = consumer.
interface toggle_event_decoder_if #(
    parameter int unsigned CNT_W = 4
);
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_count;

    modport master (
        output evt_valid,
        output evt_count,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_count,
        output evt_ready
    );
endinterface

// File: rtl/toggle_event_decoder_edge.sv
// Edge detector for a toggle-encoded input.
// Optional macro TOGGLE_DEC_SYNC_EN adds a two-flop synchroniser (s0->s1)
// ahead of the r0/r1 detector for an asynchronous tgl_in.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   tgl_in    : toggle-encoded input
//   evt_edge  : combinational r0^r1, the increment strobe for the counter
//   evt_pulse : registered one-cycle pulse per level change
module toggle_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic tgl_in,
    output logic evt_edge,
    output logic evt_pulse
);
    logic din;
    logic r0;
    logic r1;

`ifdef TOGGLE_DEC_SYNC_EN
    logic s0;
    logic s1;

    // Reset preloads the current level so it is not seen as an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= tgl_in;
            s1 <= tgl_in;
        end else begin
            s0 <= tgl_in;
            s1 <= s0;
        end
    end

    assign din = s1;
`else
    assign din = tgl_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r0        <= tgl_in;
            r1        <= tgl_in;
            evt_pulse <= 1'b0;
        end else begin
            r0        <= din;
            r1        <= r0;
            evt_pulse <= r0 ^ r1;
        end
    end

    assign evt_edge = r0 ^ r1;

endmodule

// File: rtl/toggle_event_decoder.sv
// Receive side of toggle-encoded event signalling. Each level change of
// tgl_in produces a one-cycle evt_pulse and is queued in a saturating
// pending-event counter that a consumer drains over a valid/ready handshake.
// Optional macro TOGGLE_DEC_SYNC_EN: two-flop input synchroniser.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   tgl_in    : toggle-encoded input
//   evt_pulse : one-cycle pulse per detected level change
//   ovf       : sticky, an event was lost at saturation
//   ovf_clr   : clears ovf (a simultaneous loss wins)
//   evt       : valid/ready/count handshake (master modport)
module toggle_event_decoder
    import toggle_dec_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tgl_in,
    output logic                          evt_pulse,
    output logic                          ovf,
    input  logic                          ovf_clr,
    toggle_event_decoder_if.master        evt
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    dec_state_t       state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             valid_q;
    logic             evt_edge;
    logic             inc;
    logic             dec;
    logic             lost;

    toggle_edge_detect u_edge (
        .clk       (clk),
        .rst       (rst),
        .tgl_in    (tgl_in),
        .evt_edge  (evt_edge),
        .evt_pulse (evt_pulse)
    );

    assign inc = evt_edge;
    assign dec = valid_q & evt.evt_ready;

    // inc & dec together leave the count untouched, even at saturation.
    always_comb begin
        count_nxt = count;
        lost      = 1'b0;
        if (inc && !dec) begin
            if (count == CNT_MAX) begin
                lost = 1'b1;
            end else begin
                count_nxt = count + CNT_ONE;
            end
        end else if (dec && !inc) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            valid_q <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            count   <= count_nxt;
            valid_q <= (count_nxt != '0);

            if (lost) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (inc && !dec) begin
                        state <= (count_nxt == CNT_MAX) ? FULL : PEND;
                    end
                end
                PEND: begin
                    if (dec && !inc && count == CNT_ONE) begin
                        state <= IDLE;
                    end else if (inc && !dec && count == CNT_MAX - CNT_ONE) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (dec && !inc) begin
                        state <= (count_nxt == '0) ? IDLE : PEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_count = count;

endmodule

// File: tb/tb_toggle_event_decoder.sv
module tb_toggle_event_decoder;
    import toggle_dec_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned MAX   = 15;
`ifdef TOGGLE_DEC_SYNC_EN
    localparam int unsigned LAT = 4;
`else
    localparam int unsigned LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tgl_in;
    logic evt_pulse;
    logic ovf;
    logic ovf_clr;

    toggle_event_decoder_if #(.CNT_W(CNT_W)) evt_if ();

    toggle_event_decoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgl_in    (tgl_in),
        .evt_pulse (evt_pulse),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .evt       (evt_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: each accepted input change pushes the cycle at which its
    // pulse and count increment are due.
    int unsigned pq[$];
    int unsigned cyc      = 0;
    int unsigned m_cnt    = 0;
    bit          m_ovf    = 0;
    bit          m_valid  = 0;
    bit          m_pulse  = 0;
    bit          last_tgl = 0;
    bit          mon_en   = 0;

    always @(posedge clk) begin
        bit inc, dec, lost;
        cyc++;
        if (rst) begin
            pq.delete();
            m_cnt    = 0;
            m_ovf    = 0;
            m_valid  = 0;
            m_pulse  = 0;
            last_tgl = tgl_in;
        end else begin
            if (tgl_in != last_tgl) begin
                pq.push_back(cyc + LAT - 1);
                last_tgl = tgl_in;
            end
            inc = (pq.size() > 0) && (pq[0] == cyc);
            if (inc) void'(pq.pop_front());
            dec  = m_valid && evt_if.evt_ready;
            lost = 0;
            if (inc && !dec) begin
                if (m_cnt == MAX) lost = 1;
                else m_cnt++;
            end else if (dec && !inc) begin
                m_cnt--;
            end
            if (lost) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_valid = (m_cnt != 0);
            m_pulse = inc;
        end
        mon_en = 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("pulse", int'(evt_pulse), int'(m_pulse));
            chk("count", int'(evt_if.evt_count), int'(m_cnt));
            chk("valid", int'(evt_if.evt_valid), int'(m_valid));
            chk("ovf",   int'(ovf), int'(m_ovf));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic lvl);
        rst    = 1'b1;
        tgl_in = lvl;
        tick(2);
        rst    = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        tgl_in             = 1'b1;
        ovf_clr            = 1'b0;
        evt_if.evt_ready   = 1'b0;

        // 1: reset with tgl_in high, release, nothing happens
        do_reset(1'b1);
        chk("rst_count", int'(evt_if.evt_count), 0);
        chk("rst_ovf", int'(ovf), 0);
        tick(10);
        chk("t1_count", int'(evt_if.evt_count), 0);

        // 2: single 0->1 event
        do_reset(1'b0);
        tick(1);
        tgl_in = 1'b1;
        tick(LAT + 2);
        chk("t2_count", int'(evt_if.evt_count), 1);
        chk("t2_valid", int'(evt_if.evt_valid), 1);

        // 3: 16 back-to-back toggles saturate the counter
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            tgl_in = ~tgl_in;
        end
        tick(LAT + 2);
        chk("t3_count", int'(evt_if.evt_count), 15);
        chk("t3_ovf", int'(ovf), 1);

        // ovf_clr clears the sticky flag
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        tick(1);
        chk("clr_ovf", int'(ovf), 0);

        // 4: at MAX, toggle with ready on the increment cycle -> no overflow
        tgl_in = ~tgl_in;
        tick(LAT - 1);
        evt_if.evt_ready = 1'b1;
        tick(1);
        evt_if.evt_ready = 1'b0;
        tick(2);
        chk("t4_count", int'(evt_if.evt_count), 15);
        chk("t4_ovf", int'(ovf), 0);

        // loss and ovf_clr on the same cycle: set wins
        tgl_in = ~tgl_in;
        tick(LAT - 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        tick(1);
        chk("setwins_ovf", int'(ovf), 1);

        // 5: drain three events, extra ready ignored
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            tgl_in = ~tgl_in;
        end
        tick(LAT + 2);
        chk("t5_count3", int'(evt_if.evt_count), 3);
        evt_if.evt_ready = 1'b1;
        tick(6);
        evt_if.evt_ready = 1'b0;
        chk("t5_count0", int'(evt_if.evt_count), 0);
        chk("t5_valid", int'(evt_if.evt_valid), 0);

        // 6: count=5 with ovf set, in-flight toggle, then one-cycle reset
        for (int i = 0; i < 17; i++) begin
            tick(1);
            tgl_in = ~tgl_in;
        end
        tick(LAT + 2);
        evt_if.evt_ready = 1'b1;
        tick(10);
        evt_if.evt_ready = 1'b0;
        chk("t6_count5", int'(evt_if.evt_count), 5);
        chk("t6_ovf1", int'(ovf), 1);
        tgl_in = ~tgl_in;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_count0", int'(evt_if.evt_count), 0);
        chk("t6_ovf0", int'(ovf), 0);
        tick(LAT + 4);
        chk("t6_after", int'(evt_if.evt_count), 0);

        // random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if ($urandom_range(0, 2) == 0) tgl_in = ~tgl_in;
            evt_if.evt_ready = ($urandom_range(0, 3) == 0);
            ovf_clr          = ($urandom_range(0, 15) == 0);
        end
        evt_if.evt_ready = 1'b0;
        ovf_clr          = 1'b0;
        tick(LAT + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
